// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for the clock period meter.
// FSM encoding is fixed so it stays stable across revisions.
package clk_period_meter_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_e;

endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
module clk_period_meter_sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic sync,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q   <= '0;
      sync_d_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], async_in};
      sync_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync       = sync_q[SYNC_STAGES-1];
  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~sync_d_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous clock in clk_in cycles, with
// stopped-clock detection, expected-period match and a valid/ready result port.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned EXP_PERIOD  = 2,
  parameter int unsigned TOL         = 0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             meas_clk,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             stopped,
  output logic             match
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W:0]   EXP_C     = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, overrun_q, overrun_d;
  logic             stopped_q, stopped_d, match_q, match_d;

  logic             meas_sync, meas_edge;
  logic             capture;
  logic [CNT_W:0]   cnt_ext, mag;
  logic             period_ok;

  clk_period_meter_sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in    (clk_in),
    .rst       (rst),
    .async_in  (meas_clk),
    .sync      (meas_sync),
    .edge_pulse(meas_edge)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    stopped_d = stopped_q;
    match_d   = match_q;
    capture   = 1'b0;

    // Unsigned distance from the expected period, one bit wider to avoid wrap.
    cnt_ext = {1'b0, cnt_q};
    if (cnt_ext >= EXP_C) mag = cnt_ext - EXP_C;
    else                  mag = EXP_C - cnt_ext;
    period_ok = (mag <= TOL_C);

    if (!en) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      hcnt_d    = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      stopped_d = 1'b0;
      match_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          hcnt_d  = '0;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          if (meas_edge) begin
            cnt_d     = ONE_C;
            hcnt_d    = ONE_C;
            stopped_d = 1'b0;
            state_d   = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // An edge on the timeout cycle still counts as a valid period.
          if (meas_edge) begin
            capture = 1'b1;
            cnt_d   = ONE_C;
            hcnt_d  = ONE_C;
          end else if (cnt_q == TIMEOUT_C) begin
            stopped_d = 1'b1;
            match_d   = 1'b0;
            cnt_d     = '0;
            hcnt_d    = '0;
            state_d   = ST_ARM;
          end else begin
            cnt_d  = cnt_q + ONE_C;
            hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, meas_sync};
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (capture) begin
        period_d = cnt_q;
        high_d   = hcnt_q;
        match_d  = period_ok;
        valid_d  = 1'b1;
        if (valid_q && !ready) overrun_d = 1'b1;
      end else if (valid_q && ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      stopped_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      stopped_q <= stopped_d;
      match_q   <= match_d;
    end
  end

  assign period   = period_q;
  assign high_cnt = high_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;
  assign stopped  = stopped_q;
  assign match    = match_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench: expected results come from the pin waveform (rise-to-rise distance,
// high width), a monitor compares them whenever a result is handed over.
module tb_clk_period_meter;

  localparam int CNT_W      = 16;
  localparam int SYNC       = 2;
  localparam int TIMEOUT    = 100;
  localparam int EXP_PERIOD = 4;
  localparam int TOL        = 1;

  typedef struct {
    int period;
    int high;
    bit m;
  } res_t;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             meas_clk = 1'b0;
  logic             en = 1'b0;
  logic             ready = 1'b0;
  logic [CNT_W-1:0] period, high_cnt;
  logic             valid, overrun, stopped, match;

  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;
  int   prev_rise = 0;
  int   prev_h = 0;
  int   rise_cyc = 0;
  int   zeros = 0;
  bit   have_prev = 1'b0;
  bit   sb_push = 1'b1;
  bit   rand_ready = 1'b0;
  res_t last_exp;
  res_t exp_q[$];

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TIMEOUT),
    .EXP_PERIOD (EXP_PERIOD),
    .TOL        (TOL)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .meas_clk(meas_clk),
    .en      (en),
    .period  (period),
    .high_cnt(high_cnt),
    .valid   (valid),
    .ready   (ready),
    .overrun (overrun),
    .stopped (stopped),
    .match   (match)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic bit exp_match(input int p);
    int d;
    d = p - EXP_PERIOD;
    if (d < 0) d = -d;
    return d <= TOL;
  endfunction

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    cyc_n++;
    if (rand_ready) begin
      if (zeros >= 2) ready = 1'b1;
      else            ready = ($urandom_range(2, 0) != 0);
      zeros = ready ? 0 : zeros + 1;
    end
  endtask

  // One meas_clk pulse: high for h cycles, then low for l cycles.
  task automatic pulse(input int h, input int l);
    int d;
    step();
    meas_clk = 1'b1;
    d = cyc_n - prev_rise;
    if (have_prev && d <= TIMEOUT) begin
      last_exp.period = d;
      last_exp.high   = prev_h;
      last_exp.m      = exp_match(d);
      if (sb_push) exp_q.push_back(last_exp);
    end
    prev_rise = cyc_n;
    prev_h    = h;
    have_prev = 1'b1;
    repeat (h - 1) step();
    step();
    meas_clk = 1'b0;
    repeat (l - 1) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_high_cnt"}, 32'(high_cnt), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_stopped"}, 32'(stopped), 0);
    chk({tag, "_match"}, 32'(match), 0);
  endtask

  always @(negedge clk_in) begin
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got period %0d high %0d, expected no result",
                 period, high_cnt);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sb_period", 32'(period), e.period);
        chk("sb_high_cnt", 32'(high_cnt), e.high);
        chk("sb_match", 32'(match), 32'(e.m));
      end
    end
  end

  initial begin
    repeat (3) step();
    chk_all_zero("reset");

    rst = 1'b0;
    en = 1'b1;
    rand_ready = 1'b1;
    repeat (2) step();

    // Known shapes, random shapes, then periods exactly at and just past the timeout.
    repeat (3) pulse(2, 2);
    pulse(3, 7);
    pulse(2, 3);
    pulse(3, 2);
    for (int i = 0; i < 30; i++) pulse($urandom_range(20, 2), $urandom_range(20, 2));
    pulse(50, 50);
    pulse(30, 71);
    pulse(3, 3);
    pulse(2, 2);

    // Pin held low: stopped rises TIMEOUT cycles after the last edge's count starts.
    rise_cyc = prev_rise;
    while (cyc_n < rise_cyc + TIMEOUT + SYNC) step();
    chk("stopped_before_timeout", 32'(stopped), 0);
    step();
    chk("stopped_at_timeout", 32'(stopped), 1);
    chk("match_after_timeout", 32'(match), 0);
    chk("valid_after_timeout", 32'(valid), 0);
    chk("overrun_random_phase", 32'(overrun), 0);
    repeat (20) step();
    chk("stopped_held", 32'(stopped), 1);

    pulse(3, 3);
    chk("stopped_cleared_on_edge", 32'(stopped), 0);
    pulse(2, 2);
    pulse(2, 3);
    repeat (4) step();

    // Three captures while the consumer stalls.
    rand_ready = 1'b0;
    ready = 1'b0;
    sb_push = 1'b0;
    pulse(2, 2);
    pulse(3, 3);
    pulse(2, 2);
    step();
    chk("stall_valid", 32'(valid), 1);
    chk("stall_overrun", 32'(overrun), 1);
    exp_q.push_back(last_exp);
    step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("drain_valid", 32'(valid), 0);
    chk("drain_overrun_sticky", 32'(overrun), 1);

    // Drop en for one cycle with valid, overrun and match all set.
    pulse(2, 2);
    pulse(2, 3);
    chk("pre_en_valid", 32'(valid), 1);
    chk("pre_en_overrun", 32'(overrun), 1);
    chk("pre_en_match", 32'(match), 1);
    en = 1'b0;
    step();
    en = 1'b1;
    have_prev = 1'b0;
    chk("en_low_valid", 32'(valid), 0);
    chk("en_low_overrun", 32'(overrun), 0);
    chk("en_low_stopped", 32'(stopped), 0);
    chk("en_low_match", 32'(match), 0);
    chk("en_low_period_kept", 32'(period), last_exp.period);
    chk("en_low_high_kept", 32'(high_cnt), last_exp.high);

    // Reset in the middle of a measurement.
    ready = 1'b1;
    sb_push = 1'b1;
    repeat (2) step();
    pulse(3, 4);
    pulse(2, 5);
    chk("pre_rst_period", 32'(period), 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    have_prev = 1'b0;
    chk_all_zero("mid_rst");
    repeat (2) step();
    pulse(2, 2);
    pulse(3, 3);
    pulse(2, 4);
    repeat (30) step();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
